// File: rtl/spi_defs.sv
// Shared definitions for the SPI peripheral datapath: FSM encodings and
// bit-order constants used by the shift engine and its bit counter.
package spi_defs;

    typedef enum logic {
        SPI_IDLE   = 1'b0,
        SPI_ACTIVE = 1'b1
    } spiState_e;

    localparam logic SPI_MSB_FIRST = 1'b0;
    localparam logic SPI_LSB_FIRST = 1'b1;

endpackage

// File: rtl/shift_bit_counter.sv
// Per-word shift counter. Counts completed shifts, wraps to zero on the
// shift that completes a word, and flags the terminal count so the engine
// can recognise that the next shift finishes the word.
module shift_bit_counter #(
    parameter int WIDTH = 8,
    localparam int CW   = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          terminal
);

    logic [CW-1:0] count_r;
    logic          terminal_s;

    // Terminal when the counter sits at the last bit position of the word.
    always_comb begin
        terminal_s = (count_r == CW'(WIDTH - 1));
    end

    // Counter register: clear restarts the word, inc advances or wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {CW{1'b0}};
        end else if (clear) begin
            count_r <= {CW{1'b0}};
        end else if (inc) begin
            if (terminal_s) begin
                count_r <= {CW{1'b0}};
            end else begin
                count_r <= count_r + CW'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

    assign count    = count_r;
    assign terminal = terminal_s;

endmodule

// File: rtl/spi_shift_engine.sv
// Word-framed SPI shift engine: independent sample and shift strobes,
// MSB/LSB-first order chosen at load time, bit counting with a one-cycle
// word-complete pulse, and a holding register for each received word.
module spi_shift_engine
    import spi_defs::*;
#(
    parameter int WIDTH = 8,
    localparam int CW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sampleEdge,
    input  logic             shiftEdge,
    input  logic             parallelLoad,
    input  logic [WIDTH-1:0] parallelDataIn,
    input  logic             lsbFirst,
    input  logic             serialDataIn,
    output logic [WIDTH-1:0] parallelDataOut,
    output logic             serialDataOut,
    output logic [WIDTH-1:0] rxData,
    output logic             wordDone,
    output logic             busy,
    output logic [CW-1:0]    bitCount
);

    logic [WIDTH-1:0] shiftReg_r;
    logic             sampledBit_r;
    logic             modeLsb_r;
    logic [WIDTH-1:0] rxData_r;
    logic             wordDone_r;
    spiState_e        state_r;
    spiState_e        stateNext_s;

    logic             shiftNow_s;
    logic             sampleNow_s;
    logic             insertBit_s;
    logic [WIDTH-1:0] shiftNext_s;
    logic             terminal_s;
    logic             complete_s;

    // Strobe qualification: a load in the same cycle swallows both strobes.
    // A coincident sample feeds the live serial input straight into the shift.
    always_comb begin
        shiftNow_s  = shiftEdge & ~parallelLoad;
        sampleNow_s = sampleEdge & ~parallelLoad;
        if (sampleEdge) begin
            insertBit_s = serialDataIn;
        end else begin
            insertBit_s = sampledBit_r;
        end
        complete_s = shiftNow_s & terminal_s;
    end

    // Post-shift register value in the bit order latched at the last load.
    always_comb begin
        shiftNext_s = shiftReg_r;
        if (modeLsb_r == SPI_LSB_FIRST) begin
            shiftNext_s = {insertBit_s, shiftReg_r[WIDTH-1:1]};
        end else begin
            shiftNext_s = {shiftReg_r[WIDTH-2:0], insertBit_s};
        end
    end

    shift_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bitCounter (
        .clk      (clk),
        .reset    (reset),
        .clear    (parallelLoad),
        .inc      (shiftNow_s),
        .count    (bitCount),
        .terminal (terminal_s)
    );

    // Next-state logic: load or any strobe starts a word, completion ends it.
    always_comb begin
        stateNext_s = state_r;
        if (parallelLoad) begin
            stateNext_s = SPI_ACTIVE;
        end else if (complete_s) begin
            stateNext_s = SPI_IDLE;
        end else if (shiftNow_s || sampleNow_s) begin
            stateNext_s = SPI_ACTIVE;
        end else begin
            stateNext_s = state_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= SPI_IDLE;
        end else begin
            state_r <= stateNext_s;
        end
    end

    // Datapath registers: load, sample, shift, and word-completion capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            shiftReg_r   <= {WIDTH{1'b0}};
            sampledBit_r <= 1'b0;
            modeLsb_r    <= SPI_MSB_FIRST;
            rxData_r     <= {WIDTH{1'b0}};
            wordDone_r   <= 1'b0;
        end else if (parallelLoad) begin
            shiftReg_r <= parallelDataIn;
            modeLsb_r  <= lsbFirst;
            wordDone_r <= 1'b0;
        end else begin
            if (shiftNow_s) begin
                shiftReg_r <= shiftNext_s;
            end
            if (sampleNow_s) begin
                sampledBit_r <= serialDataIn;
            end
            if (complete_s) begin
                rxData_r <= shiftNext_s;
            end
            wordDone_r <= complete_s;
        end
    end

    assign parallelDataOut = shiftReg_r;
    assign serialDataOut   = (modeLsb_r == SPI_LSB_FIRST) ? shiftReg_r[0] : shiftReg_r[WIDTH-1];
    assign rxData          = rxData_r;
    assign wordDone        = wordDone_r;
    assign busy            = (state_r == SPI_ACTIVE);

endmodule
